// File: rtl/aes_pkg.sv
// Shared AES constants, FSM states and GF(2^8) helpers.
// Used by aes_cipher and aes_enc_round; no ports.
package aes_pkg;

  localparam logic [1:0] MODE_128  = 2'b00;
  localparam logic [1:0] MODE_192  = 2'b01;
  localparam logic [1:0] MODE_256  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  localparam logic [4:0] NR_128 = 5'd10;
  localparam logic [4:0] NR_192 = 5'd12;
  localparam logic [4:0] NR_256 = 5'd14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Forward S-box, entry b at bits [8b +: 8].
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round.
// Ports: i_state, i_round_key, i_is_final (skip MixColumns) -> o_state.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [0:127] i_state,
  input  logic [0:127] i_round_key,
  input  logic         i_is_final,
  output logic [0:127] o_state
);

  logic [7:0] w_sb [0:15];
  logic [7:0] w_sr [0:15];
  logic [7:0] w_mc [0:15];

  // Byte k sits at row k%4, column k/4.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_sb[k] = sbox(i_state[8*k +: 8]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_sr[r + 4*c] = w_sb[r + 4*((c + r) & 3)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mc[4*c] = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1])
        ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+1] = w_sr[4*c] ^ xtime(w_sr[4*c+1])
        ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
      w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1]
        ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
      w_mc[4*c+3] = xtime(w_sr[4*c]) ^ w_sr[4*c]
        ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_ark
    assign o_state[8*k +: 8] = (i_is_final ? w_sr[k] : w_mc[k])
      ^ i_round_key[8*k +: 8];
  end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128/192/256 encryption, one round per clock.
// Ports: CLK, reset, start, mode, plain_in, round_key/key_round/key_valid in; cipher_out, done, busy, exp_round out.
module aes_cipher
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [0:127] plain_in,
  input  logic [0:127] round_key,
  input  logic [4:0]   key_round,
  input  logic         key_valid,
  output logic [0:127] cipher_out,
  output logic         done,
  output logic         busy,
  output logic [4:0]   exp_round
);

  state_e       r_fsm;
  state_e       w_fsm_nxt;
  logic [0:127] r_state;
  logic [0:127] r_cipher;
  logic [4:0]   r_round;
  logic [1:0]   r_mode;

  logic [4:0]   w_nr;
  logic         w_start_ok;
  logic         w_adv;
  logic         w_final;
  logic [0:127] w_round_out;
  logic [0:127] w_nxt;

  always_comb begin
    w_nr = NR_128;
    case (r_mode)
      MODE_128: w_nr = NR_128;
      MODE_192: w_nr = NR_192;
      MODE_256: w_nr = NR_256;
      default:  w_nr = NR_128;
    endcase
  end

  assign w_start_ok = start && (mode != MODE_RSVD);
  // Advance only on the key for exactly this round; anything else stalls.
  assign w_adv      = key_valid && (key_round == r_round);
  assign w_final    = (r_round == w_nr);

  aes_enc_round u_round (
    .i_state     (r_state),
    .i_round_key (round_key),
    .i_is_final  (w_final),
    .o_state     (w_round_out)
  );

  assign w_nxt = (r_round == 5'd0) ? (r_state ^ round_key) : w_round_out;

  always_ff @(posedge CLK) begin
    if (reset) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      S_IDLE:  if (w_start_ok) w_fsm_nxt = S_RUN;
      S_RUN:   if (w_adv && w_final) w_fsm_nxt = S_DONE;
      S_DONE:  if (w_start_ok) w_fsm_nxt = S_RUN;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done      = (r_fsm == S_DONE);
    busy      = (r_fsm == S_RUN);
    exp_round = busy ? r_round : 5'd0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= '0;
      r_cipher <= '0;
      r_round  <= '0;
      r_mode   <= MODE_128;
    end else if ((r_fsm != S_RUN) && w_start_ok) begin
      r_state <= plain_in;
      r_mode  <= mode;
      r_round <= '0;
    end else if ((r_fsm == S_RUN) && w_adv) begin
      r_state <= w_nxt;
      r_round <= r_round + 5'd1;
      if (w_final) r_cipher <= w_round_out;
    end
  end

  assign cipher_out = r_cipher;

endmodule

// File: tb/tb_aes_cipher.sv
// Self-checking bench for aes_cipher with FIPS-197 vectors.
// Streams round keys from an independent key-schedule model.
module tb_aes_cipher;

  logic         CLK;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [0:127] plain_in;
  logic [0:127] round_key;
  logic [4:0]   key_round;
  logic         key_valid;
  logic [0:127] cipher_out;
  logic         done;
  logic         busy;
  logic [4:0]   exp_round;

  aes_cipher dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .plain_in   (plain_in),
    .round_key  (round_key),
    .key_round  (key_round),
    .key_valid  (key_valid),
    .cipher_out (cipher_out),
    .done       (done),
    .busy       (busy),
    .exp_round  (exp_round)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [0:127] pt;
    logic [0:255] key;
    logic [1:0]   md;
    logic [0:127] ct;
    int           lat;
    bit           poke;
    bit           stall;
  } vec_t;

  vec_t         tv [0:4];
  logic [7:0]   sb [0:255];
  logic [0:127] rk [0:15];
  logic [0:127] exp_hold;
  int           n_chk;
  int           n_pass;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, want);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from field inverse plus affine map, independent of the RTL table.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [0:255] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= nr; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic run(input vec_t v, input int abort_at,
                     output logic [0:127] ct, output int cyc);
    logic [31:0] smask;
    logic [31:0] bmask;
    logic [4:0]  er;
    int          nk;
    int          p;
    int          cnt;
    bit          stl;
    nk = (v.md == 2'b01) ? 6 : (v.md == 2'b10) ? 8 : 4;
    expand(v.key, nk);
    smask = '0;
    bmask = '0;
    cnt = 0;
    while (v.stall && cnt < 4) begin
      p = $urandom_range(0, 9);
      if (!smask[p] && !bmask[p]) begin
        if (cnt < 3) smask[p] = 1'b1;
        else         bmask[p] = 1'b1;
        cnt++;
      end
    end
    start = 1'b1;
    plain_in = v.pt;
    mode = v.md;
    key_valid = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    plain_in = ~v.pt;
    mode = 2'b11;
    chk("run_entry_busy_done", {busy, done}, 2'b10);
    chk("cipher_hold_at_start", cipher_out, exp_hold);
    cyc = 0;
    ct = '0;
    while (cyc < 60) begin
      er = exp_round;
      if (abort_at >= 0 && int'(er) == abort_at) begin
        reset = 1'b1;
        key_valid = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b0;
        chk("rst_cipher_out", cipher_out, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_exp_round", exp_round, 5'd0);
        exp_hold = '0;
        return;
      end
      stl = 1'b0;
      if (smask[cyc]) begin
        key_valid = 1'b0;
        stl = 1'b1;
      end else if (bmask[cyc]) begin
        key_valid = 1'b1;
        key_round = er + 5'd1;
        round_key = rk[(er + 5'd1) & 5'd15];
        stl = 1'b1;
      end else begin
        key_valid = 1'b1;
        key_round = er;
        round_key = rk[er];
      end
      if (v.poke && cyc == 2) begin
        start = 1'b1;
        plain_in = ~v.pt;
        mode = 2'b00;
      end else begin
        start = 1'b0;
        mode = 2'b11;
      end
      @(posedge CLK); #1;
      cyc++;
      if (stl) chk("stall_exp_round_hold", exp_round, er);
      if (done) break;
    end
    start = 1'b0;
    key_valid = 1'b0;
    if (!done) chk("done_timeout", 1'b0, 1'b1);
    ct = cipher_out;
  endtask

  logic [0:127] got;
  int           lat;
  vec_t         vb;

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    plain_in = '0;
    round_key = '0;
    key_round = '0;
    key_valid = 1'b0;
    exp_hold = '0;
    build_sbox();

    tv[0] = '{128'h3243f6a8885a308d313198a2e0370734,
              {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              2'b00, 128'h3925841d02dc09fbdc118597196a0b32,
              11, 1'b0, 1'b0};
    tv[1] = '{128'h00112233445566778899aabbccddeeff,
              {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              11, 1'b0, 1'b0};
    tv[2] = '{128'h00112233445566778899aabbccddeeff,
              {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
               64'h0},
              2'b01, 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
              13, 1'b1, 1'b0};
    tv[3] = '{128'h00112233445566778899aabbccddeeff,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              2'b10, 128'h8ea2b7ca516745bfeafc49904b496089,
              15, 1'b0, 1'b0};
    tv[4] = '{128'h00112233445566778899aabbccddeeff,
              {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              2'b00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              15, 1'b0, 1'b1};

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_cipher_out", cipher_out, '0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_exp_round", exp_round, 5'd0);
    reset = 1'b0;

    start = 1'b1;
    mode = 2'b11;
    plain_in = tv[0].pt;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("mode11_busy", busy, 1'b0);
    chk("mode11_done", done, 1'b0);
    chk("mode11_exp_round", exp_round, 5'd0);

    for (int i = 0; i < 5; i++) begin
      run(tv[i], -1, got, lat);
      chk($sformatf("vec%0d_cipher", i), got, tv[i].ct);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(tv[i].lat));
      exp_hold = tv[i].ct;
    end

    run(tv[3], 5, got, lat);
    vb = tv[0];
    run(vb, -1, got, lat);
    chk("after_reset_cipher", got, vb.ct);
    chk("after_reset_latency", 128'(lat), 128'(11));

    repeat (3) @(posedge CLK);
    #1;
    chk("done_level_hold", done, 1'b1);
    chk("done_cipher_hold", cipher_out, vb.ct);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
